// File: rtl/exu_pkg.sv
// Shared EXU definitions: datapath width, mul_div_op bit positions and
// the state encoding of the multi-cycle arithmetic sequencer.
package exu_pkg;

    localparam int DW = 32;

    // Bit positions inside the 10-bit mul_div_op field
    localparam int MD_MUL   = 0;
    localparam int MD_MULH  = 1;
    localparam int MD_MULHU = 2;
    localparam int MD_DIV   = 3;
    localparam int MD_DIVU  = 4;
    localparam int MD_MOD   = 5;
    localparam int MD_MODU  = 6;

    typedef enum logic [2:0] {
        MD_IDLE    = 3'd0,
        MD_MUL_RUN = 3'd1,
        MD_DIV_RUN = 3'd2,
        MD_HOLD    = 3'd3,
        MD_DRAIN   = 3'd4
    } md_state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiplier and iterative divider: launches one
// unit per instruction, holds operands and request until done, captures the
// result and drains stale completions after a flush.
module muldiv_ctrl
    import exu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          issue_valid,
    input  logic          issue_new,
    input  logic          excp,
    input  logic [9:0]    op,
    input  logic [DW-1:0] src1,
    input  logic [DW-1:0] src2,
    output logic          mul_req,
    output logic [2:0]    mul_op,
    input  logic          mul_done,
    input  logic [DW-1:0] mul_res,
    output logic          div_req,
    output logic          div_signed,
    input  logic          div_done,
    input  logic [DW-1:0] div_quo,
    input  logic [DW-1:0] div_rem,
    output logic [DW-1:0] opa,
    output logic [DW-1:0] opb,
    output logic          ready_go,
    output logic [DW-1:0] result,
    output logic          busy
);

    md_state_e     state_q, state_d;
    logic [6:0]    op_q, op_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] result_q, result_d;
    logic          mul_req_q, mul_req_d;
    logic          div_req_q, div_req_d;
    logic          busy_q, busy_d;

    logic is_mul, is_div, is_md, launch;
    logic run_is_div, run_is_quo;
    logic unused_op;

    // Reserved op bits carry no meaning for this controller
    assign unused_op = ^op[9:7];

    // Decode of the instruction currently held in EXU
    always_comb begin
        is_mul = |op[MD_MULHU:MD_MUL];
        is_div = |op[MD_MODU:MD_DIV];
        is_md  = is_mul | is_div;
        // Launch one cycle after the instruction lands so the op is stable
        launch = issue_valid & is_md & ~excp & ~flush & ~issue_new;
    end

    // Decode of the latched op of the operation in flight
    always_comb begin
        run_is_div = |op_q[MD_MODU:MD_DIV];
        run_is_quo = op_q[MD_DIV] | op_q[MD_DIVU];
    end

    // Next-state and capture logic for the sequencer
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        case (state_q)
            MD_IDLE: begin
                if (launch) begin
                    op_d    = op[MD_MODU:MD_MUL];
                    opa_d   = src1;
                    opb_d   = src2;
                    state_d = is_mul ? MD_MUL_RUN : MD_DIV_RUN;
                end
            end
            MD_MUL_RUN: begin
                if (flush && mul_done) begin
                    state_d = MD_IDLE;
                end else if (flush) begin
                    state_d = MD_DRAIN;
                end else if (mul_done) begin
                    result_d = mul_res;
                    state_d  = MD_HOLD;
                end
            end
            MD_DIV_RUN: begin
                if (flush && div_done) begin
                    state_d = MD_IDLE;
                end else if (flush) begin
                    state_d = MD_DRAIN;
                end else if (div_done) begin
                    result_d = run_is_quo ? div_quo : div_rem;
                    state_d  = MD_HOLD;
                end
            end
            MD_HOLD: begin
                // Never relaunch a completed op while MEM stalls
                if (issue_new || flush) begin
                    state_d = MD_IDLE;
                end
            end
            MD_DRAIN: begin
                // Only the unit that was running can retire the drain
                if (run_is_div ? div_done : mul_done) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        mul_req_d = (state_d == MD_MUL_RUN);
        div_req_d = (state_d == MD_DIV_RUN);
        busy_d    = (state_d != MD_IDLE);
    end

    // State, operand, result and registered request flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            mul_req_q <= 1'b0;
            div_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            mul_req_q <= mul_req_d;
            div_req_q <= div_req_d;
            busy_q    <= busy_d;
        end
    end

    // Output drive; ready_go lets non-md or dying instructions pass at once
    always_comb begin
        mul_req    = mul_req_q;
        div_req    = div_req_q;
        mul_op     = op_q[MD_MULHU:MD_MUL];
        div_signed = op_q[MD_DIV] | op_q[MD_MOD];
        opa        = opa_q;
        opb        = opb_q;
        result     = result_q;
        busy       = busy_q;
        ready_go   = flush | excp | ~is_md | (state_q == MD_HOLD);
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: the bench plays both arithmetic
// units, queues the expected result at launch and compares on completion.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, issue_new, excp;
    logic [9:0]  op;
    logic [31:0] src1, src2;
    logic        mul_req, div_req, div_signed, mul_done, div_done;
    logic [2:0]  mul_op;
    logic [31:0] mul_res, div_quo, div_rem, opa, opb, result;
    logic        ready_go, busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prev_res;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
        .issue_new(issue_new), .excp(excp), .op(op), .src1(src1), .src2(src2),
        .mul_req(mul_req), .mul_op(mul_op), .mul_done(mul_done), .mul_res(mul_res),
        .div_req(div_req), .div_signed(div_signed), .div_done(div_done),
        .div_quo(div_quo), .div_rem(div_rem), .opa(opa), .opb(opb),
        .ready_go(ready_go), .result(result), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mul_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = {32'd0, a} * {32'd0, b};
        if (o[1]) return ps[63:32];
        if (o[2]) return pu[63:32];
        return pu[31:0];
    endfunction

    // One md instruction: arrives, launches, unit answers after lat cycles,
    // then MEM stalls for 'stall' cycles while the result must stay put.
    task automatic do_md(input logic [9:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int stall);
        logic [31:0] ex, mr, dq, dr, held;
        logic        isd;
        isd = |o[6:3];
        issue_valid = 1'b1; issue_new = 1'b1; excp = 1'b0;
        op = o; src1 = a; src2 = b;
        cyc();
        issue_new = 1'b0;
        #1;
        chk("idle_before_launch", {31'd0, busy}, 32'd0);
        chk("rdy_while_waiting", {31'd0, ready_go}, 32'd0);
        cyc();
        chk("mul_req_run", {31'd0, mul_req}, {31'd0, ~isd});
        chk("div_req_run", {31'd0, div_req}, {31'd0, isd});
        chk("opa", opa, a);
        chk("opb", opb, b);
        if (isd) chk("div_signed", {31'd0, div_signed}, {31'd0, o[3] | o[5]});
        else     chk("mul_op", {29'd0, mul_op}, {29'd0, o[2:0]});
        if (isd) begin
            if (o[3] | o[5]) begin
                dq = $signed(a) / $signed(b);
                dr = $signed(a) % $signed(b);
            end else begin
                dq = a / b;
                dr = a % b;
            end
            mr = 32'hDEAD_BEEF;
            ex = (o[3] | o[4]) ? dq : dr;
        end else begin
            mr = mul_model(o[2:0], a, b);
            dq = 32'h5555_AAAA;
            dr = 32'h1234_5678;
            ex = mr;
        end
        exp_q.push_back(ex);
        for (int i = 1; i < lat; i++) begin
            cyc();
            chk("req_held", {31'd0, mul_req | div_req}, 32'd1);
            chk("rdy_in_run", {31'd0, ready_go}, 32'd0);
        end
        mul_res = mr; div_quo = dq; div_rem = dr;
        if (isd) div_done = 1'b1; else mul_done = 1'b1;
        cyc();
        mul_done = 1'b0; div_done = 1'b0;
        mul_res = 32'hBAD0_0001; div_quo = 32'hBAD0_0002; div_rem = 32'hBAD0_0003;
        #1;
        chk("rdy_hold", {31'd0, ready_go}, 32'd1);
        chk("busy_hold", {31'd0, busy}, 32'd1);
        chk("req_off_hold", {31'd0, mul_req | div_req}, 32'd0);
        if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else chk("result", result, exp_q.pop_front());
        held = result;
        for (int i = 0; i < stall; i++) begin
            cyc();
            chk("stall_no_req", {31'd0, mul_req | div_req}, 32'd0);
            chk("stall_result", result, held);
            chk("stall_rdy", {31'd0, ready_go}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_new = 1'b0; excp = 1'b0;
        op = '0; src1 = '0; src2 = '0; mul_done = 1'b0; div_done = 1'b0;
        mul_res = '0; div_quo = '0; div_rem = '0;
        cyc(); cyc();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_reqs", {30'd0, mul_req, div_req}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_opab", opa | opb, 32'd0);
        chk("rst_ops", {28'd0, mul_op, div_signed}, 32'd0);
        rst = 1'b0;

        // Plain ALU op and an md op that already carries an exception
        issue_valid = 1'b1; issue_new = 1'b1; op = 10'd0;
        #1 chk("alu_rdy", {31'd0, ready_go}, 32'd1);
        cyc(); issue_new = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("alu_idle", {29'd0, busy, mul_req, div_req}, 32'd0);
        end
        issue_new = 1'b1; op = 10'h008; excp = 1'b1;
        #1 chk("excp_rdy", {31'd0, ready_go}, 32'd1);
        cyc(); issue_new = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("excp_idle", {29'd0, busy, mul_req, div_req}, 32'd0);
            chk("excp_rdy_hold", {31'd0, ready_go}, 32'd1);
        end
        excp = 1'b0;

        do_md(10'h008, 32'd100, 32'd7, 33, 0);
        do_md(10'h020, 32'hFFFF_FFF9, 32'd2, 5, 0);
        do_md(10'h001, 32'd6, 32'd7, 2, 5);
        do_md(10'h010, 32'hFFFF_FFF0, 32'd3, 4, 0);
        do_md(10'h004, 32'hFFFF_FFFF, 32'h0000_0010, 2, 1);
        do_md(10'h002, 32'hFFFF_FFFE, 32'h0000_0003, 3, 0);
        do_md(10'h040, 32'hFFFF_FFF9, 32'd5, 6, 0);
        do_md(10'h388, 32'hFFFF_FF9C, 32'd7, 3, 0);
        prev_res = result;

        // Flush during DIV_RUN: drain the late completion, ignore mul_done
        issue_new = 1'b1; op = 10'h008; src1 = 32'd50; src2 = 32'd5;
        cyc(); issue_new = 1'b0;
        cyc();
        chk("fl_divreq", {31'd0, div_req}, 32'd1);
        cyc();
        flush = 1'b1;
        #1 chk("fl_rdy_flush", {31'd0, ready_go}, 32'd1);
        cyc(); flush = 1'b0;
        #1;
        chk("drain_req", {30'd0, mul_req, div_req}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        chk("drain_rdy", {31'd0, ready_go}, 32'd0);
        mul_done = 1'b1; mul_res = 32'h0000_0BAD;
        cyc(); mul_done = 1'b0;
        chk("drain_other_done", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("drain_wait", {31'd0, busy}, 32'd1);
        end
        div_done = 1'b1; div_quo = 32'd999; issue_valid = 1'b0;
        cyc(); div_done = 1'b0;
        chk("drain_exit", {31'd0, busy}, 32'd0);
        chk("drain_result", result, prev_res);
        cyc();
        chk("drain_no_relaunch", {30'd0, mul_req, div_req}, 32'd0);

        // Flush coincident with done: straight to IDLE, result discarded
        issue_valid = 1'b1; issue_new = 1'b1; op = 10'h001; src1 = 32'd3; src2 = 32'd4;
        cyc(); issue_new = 1'b0;
        cyc();
        chk("fd_mulreq", {31'd0, mul_req}, 32'd1);
        flush = 1'b1; mul_done = 1'b1; mul_res = 32'd77; issue_valid = 1'b0;
        cyc(); flush = 1'b0; mul_done = 1'b0;
        chk("fd_idle", {31'd0, busy}, 32'd0);
        chk("fd_result", result, prev_res);
        chk("fd_noreq", {31'd0, mul_req}, 32'd0);

        // Reset in the middle of a divide
        issue_valid = 1'b1; issue_new = 1'b1; op = 10'h008;
        cyc(); issue_new = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc(); rst = 1'b0; issue_valid = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_req", {30'd0, mul_req, div_req}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_opa", opa, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
